inst_fetch_unit: RTL and testbench

//  Upstream neighbour of the control decoder. Holds the PC and issues word reads to

---
 rtl/inst_fetch_unit_pkg.sv | 20 ++
 rtl/inst_fetch_unit_fetch_buffer.sv | 61 ++++++
 rtl/inst_fetch_unit.sv | 85 ++++++++
 tb/tb_inst_fetch_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared constants, FSM encoding and opcode helper for the fetch unit
package inst_fetch_unit_pkg;

  localparam int          ILEN             = 32;
  localparam int          OPCODE_W         = 7;
  localparam int          PC_STEP          = 4;
  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [ILEN-1:0] inst);
    return inst[OPCODE_W-1:0];
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// inst_fetch_unit_fetch_buffer: small FIFO of {pc,inst}; flush overrides push and pop
module inst_fetch_unit_fetch_buffer
  import inst_fetch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_inst,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_inst,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign do_pop    = pop && !flush && !empty;
  assign do_push   = push && !flush && (!full || do_pop);
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  // storage needs no reset: entries are only visible once counted in
  always_ff @(posedge clk)
    if (do_push) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end

  // pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC holder issuing single-outstanding imem reads into a fetch buffer for decode
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter int              BUF_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_rvalid_i,
  input  logic [ILEN-1:0]     imem_rdata_i,
  input  logic                branch_taken_i,
  input  logic [XLEN-1:0]     branch_target_i,
  input  logic                stall_i,
  output logic                inst_valid_o,
  output logic [ILEN-1:0]     inst_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [OPCODE_W-1:0] opcode_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_inst;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            target_unused;

  assign target        = {branch_target_i[XLEN-1:2], 2'b00};
  assign target_unused = ^branch_target_i[1:0];

  // issue only with nothing outstanding, so a free slot guarantees room for the response;
  // a redirect defers issue one cycle so the new pc_q is used
  assign imem_req_o  = rstn_i && state_q == S_IDLE && !full && !branch_taken_i;
  assign imem_addr_o = pc_q;

  assign push         = state_q == S_WAIT && imem_rvalid_i && !branch_taken_i;
  assign inst_valid_o = !empty;
  assign pop          = inst_valid_o && !stall_i;
  assign inst_o       = inst_valid_o ? head_inst : '0;
  assign pc_o         = inst_valid_o ? head_pc : '0;
  assign opcode_o     = opcode_of(inst_o);

  // PC, outstanding-request PC and the IDLE/WAIT/DROP request tracker
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      pc_q     <= branch_taken_i ? target : imem_req_o ? pc_q + XLEN'(PC_STEP) : pc_q;
      req_pc_q <= imem_req_o ? pc_q : req_pc_q;
      state_q  <= state_q == S_IDLE ? (imem_req_o ? S_WAIT : S_IDLE)
                : imem_rvalid_i ? S_IDLE
                : (state_q == S_WAIT && !branch_taken_i) ? S_WAIT : S_DROP;
    end

  inst_fetch_unit_fetch_buffer #(
    .XLEN  (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .push      (push),
    .pop       (pop),
    .flush     (branch_taken_i),
    .push_pc   (req_pc_q),
    .push_inst (imem_rdata_i),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .full      (full),
    .empty     (empty)
  );

  // issue gating makes a response into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized and directed checks of the fetch unit against a queue-based model
module tb_inst_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        stall_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;

  inst_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (RPC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .opcode_o        (opcode_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          passed = 0;
  logic [63:0] q[$];
  logic [31:0] next_pc = RPC;
  logic [31:0] busy_pc = '0;
  bit          busy = 0;
  bit          stale = 0;
  int          wait_cnt = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic apply_reset();
    rstn_i = 1'b0;
    imem_rvalid_i = 1'b0;
    branch_taken_i = 1'b0;
    stall_i = 1'b0;
    #1;
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, RPC);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_opcode", opcode_o, 0);
    q.delete();
    busy = 0;
    stale = 0;
    next_pc = RPC;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt, input logic inj);
    logic        rv;
    logic        exp_req;
    logic        req_seen;
    logic        push_now;
    logic [31:0] addr_seen;
    logic [63:0] head;
    rv = (busy && wait_cnt == 0) || inj;
    stall_i = st;
    branch_taken_i = br;
    branch_target_i = tgt;
    imem_rvalid_i = rv;
    imem_rdata_i = !rv ? $urandom : busy ? word(busy_pc) : 32'hBAD0_0BAD;
    @(negedge clk_i);
    exp_req = !busy && q.size() < DEPTH && !br;
    check("req", imem_req_o, exp_req);
    if (exp_req) check("addr", imem_addr_o, next_pc);
    head = q.size() > 0 ? q[0] : 64'h0;
    check("valid", inst_valid_o, q.size() > 0);
    check("pc", pc_o, head[63:32]);
    check("inst", inst_o, head[31:0]);
    check("opcode", opcode_o, head[6:0]);
    req_seen = imem_req_o;
    addr_seen = imem_addr_o;
    @(posedge clk_i);
    push_now = 0;
    if (rv && busy) begin
      push_now = !stale && !br;
      busy = 0;
    end else if (busy) wait_cnt--;
    if (!br && q.size() > 0 && !st) void'(q.pop_front());
    if (push_now) q.push_back({busy_pc, word(busy_pc)});
    if (br) begin
      q.delete();
      next_pc = {tgt[31:2], 2'b00};
      stale = busy;
    end
    if (req_seen) begin
      busy = 1;
      stale = 0;
      busy_pc = addr_seen;
      next_pc = addr_seen + 32'd4;
      wait_cnt = $urandom_range(lat_min, lat_max) - 1;
    end
    #1;
  endtask

  initial begin
    // back-to-back fetch with single-cycle memory
    apply_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    // decode stalled: buffer fills to two entries, then drains in order
    apply_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // redirect while waiting: in-flight response dropped, refetch at 0x100
    lat_min = 2; lat_max = 2;
    apply_reset();
    step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0103, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    apply_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 32'h0000_0200, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    // reset mid-wait, stale response arrives after release
    lat_min = 3; lat_max = 3;
    apply_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    apply_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    // PC wrap past the top of the address space
    lat_min = 1; lat_max = 1;
    apply_reset();
    step(0, 1, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    // randomized traffic
    lat_min = 1; lat_max = 4;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, $urandom, 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
